// File: rtl/fc_result_drain_if.sv
// fc_result_drain_if
//   Bundles the two buses of the result drain block:
//     - result RAM read port: rd_en, rd_addr (drain -> RAM), rd_data (RAM -> drain,
//       valid one cycle after rd_addr/rd_en)
//     - lane-pair output stream: out_valid, out_data_a, out_data_b, out_last
//       (drain -> consumer), out_ready (consumer -> drain)
//   Modports:
//     master - the drain block (drives read requests and the output stream)
//     slave  - the environment (RAM and downstream consumer)
interface fc_result_drain_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7
);
    logic                         rd_en;
    logic        [ADDR_WIDTH-1:0] rd_addr;
    logic signed [DATA_WIDTH-1:0] rd_data;

    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data_a;
    logic signed [DATA_WIDTH-1:0] out_data_b;
    logic                         out_last;

    modport master (
        output rd_en, rd_addr,
        input  rd_data,
        output out_valid, out_data_a, out_data_b, out_last,
        input  out_ready
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data,
        input  out_valid, out_data_a, out_data_b, out_last,
        output out_ready
    );
endinterface

// File: rtl/fc_result_drain.sv
// fc_result_drain
//   Drains the fully connected layer's result RAM once the layer reports completion
//   and streams the entries as lane pairs (2k, 2k+1) over a valid/ready handshake.
//   Each pair takes RD0 (read 2k), RD1 (read 2k+1, capture lane a), CAP (capture
//   lane b), then PRESENT until accepted. All outputs are registered.
//
//   Optional feature macro: FC_ARGMAX_EN
//     defined   - tracks the signed argmax (strictly greater wins, so ties keep the
//                 lower index) over every drained entry
//     undefined - o_argmax_idx / o_argmax_val are tied to 0, no comparator built
//
//   Ports:
//     clk, rst      clock; synchronous active-high reset (aborts any drain)
//     i_start       begin a drain; sampled only in IDLE
//     bus           fc_result_drain_if.master (RAM read port + output stream)
//     o_busy        high in every state except IDLE
//     o_done        one-cycle pulse after the final pair is accepted
//     o_argmax_idx  index of the largest drained entry
//     o_argmax_val  value of the largest drained entry
module fc_result_drain #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_OUT    = 120,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    fc_result_drain_if.master            bus,
    output logic                         o_busy,
    output logic                         o_done,
    output logic        [ADDR_WIDTH-1:0] o_argmax_idx,
    output logic signed [DATA_WIDTH-1:0] o_argmax_val
);
    localparam int NUM_PAIRS = NUM_OUT / 2;
    localparam int K_W       = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NUM_PAIRS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD0     = 3'd1,
        RD1     = 3'd2,
        CAP     = 3'd3,
        PRESENT = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic        [K_W-1:0]        r_k;
    logic        [K_W-1:0]        w_k_inc;
    logic        [ADDR_WIDTH-1:0] w_addr_a;
    logic        [ADDR_WIDTH-1:0] w_addr_b;
    logic        [ADDR_WIDTH-1:0] w_addr_next_a;
    logic                         w_xfer;

    logic                         r_rd_en;
    logic        [ADDR_WIDTH-1:0] r_rd_addr;
    logic                         r_out_valid;
    logic signed [DATA_WIDTH-1:0] r_data_a;
    logic signed [DATA_WIDTH-1:0] r_data_b;
    logic                         r_out_last;
    logic                         r_busy;
    logic                         r_done;

    assign w_k_inc       = r_k + 1'b1;
    assign w_addr_a      = ADDR_WIDTH'({r_k, 1'b0});
    assign w_addr_b      = ADDR_WIDTH'({r_k, 1'b1});
    assign w_addr_next_a = ADDR_WIDTH'({w_k_inc, 1'b0});
    assign w_xfer        = (r_state == PRESENT) && r_out_valid && bus.out_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = RD0;
            RD0:     w_state_nxt = RD1;
            RD1:     w_state_nxt = CAP;
            CAP:     w_state_nxt = PRESENT;
            PRESENT: if (w_xfer) w_state_nxt = (r_k == K_LAST) ? DONE : RD0;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are loaded on the edge that enters the state they belong to, so each
    // state's rd_en/rd_addr/valid values are visible for the whole state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_out_valid <= 1'b0;
            r_data_a    <= '0;
            r_data_b    <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= (w_state_nxt == DONE);
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_k       <= '0;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= '0;
                    end
                end
                RD0: begin
                    r_rd_en   <= 1'b1;
                    r_rd_addr <= w_addr_b;
                end
                RD1: begin
                    // RAM word for 2k arrives during RD1
                    r_rd_en  <= 1'b0;
                    r_data_a <= bus.rd_data;
                end
                CAP: begin
                    r_data_b    <= bus.rd_data;
                    r_out_valid <= 1'b1;
                    r_out_last  <= (r_k == K_LAST);
                end
                PRESENT: begin
                    if (w_xfer) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_k != K_LAST) begin
                            r_k       <= w_k_inc;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= w_addr_next_a;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_en      = r_rd_en;
    assign bus.rd_addr    = r_rd_addr;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data_a = r_data_a;
    assign bus.out_data_b = r_data_b;
    assign bus.out_last   = r_out_last;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

`ifdef FC_ARGMAX_EN
    function automatic logic is_greater(input logic signed [DATA_WIDTH-1:0] cand,
                                        input logic signed [DATA_WIDTH-1:0] best);
        return cand > best;
    endfunction

    logic        [ADDR_WIDTH-1:0] r_amax_idx;
    logic signed [DATA_WIDTH-1:0] r_amax_val;

    // Entry 0 seeds the tracker so an all-negative buffer still reports a real entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_amax_idx <= '0;
            r_amax_val <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_amax_idx <= '0;
                        r_amax_val <= '0;
                    end
                end
                RD1: begin
                    if (r_k == '0 || is_greater(bus.rd_data, r_amax_val)) begin
                        r_amax_idx <= w_addr_a;
                        r_amax_val <= bus.rd_data;
                    end
                end
                CAP: begin
                    if (is_greater(bus.rd_data, r_amax_val)) begin
                        r_amax_idx <= w_addr_b;
                        r_amax_val <= bus.rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_argmax_idx = r_amax_idx;
    assign o_argmax_val = r_amax_val;
`else
    assign o_argmax_idx = '0;
    assign o_argmax_val = '0;
`endif
endmodule

// File: tb/tb_fc_result_drain.sv
// tb_fc_result_drain
//   Directed bench for fc_result_drain: ramp drain, random backpressure, reset
//   mid-drain, start while busy, and argmax (FC_ARGMAX_EN) or argmax tie-off.
module tb_fc_result_drain;
    localparam int DW = 16;
    localparam int AW = 7;
    localparam int NO = 120;
    localparam int NP = NO / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_start = 1'b0;
    logic o_busy, o_done;
    logic [AW-1:0] o_argmax_idx;
    logic signed [DW-1:0] o_argmax_val;

    fc_result_drain_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fc_result_drain #(.DATA_WIDTH(DW), .NUM_OUT(NO), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .bus          (bus),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_argmax_idx (o_argmax_idx),
        .o_argmax_val (o_argmax_val)
    );

    always #5 clk = ~clk;

    logic signed [DW-1:0] ram [0:127];
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stream monitor, sampled mid-cycle
    longint q_a[$];
    longint q_b[$];
    longint q_last[$];
    int n_done = 0;
    int done_cyc = 0;
    int n_rd_in_present = 0;
    int n_hold_err = 0;
    int n_amax_nz = 0;
    logic prev_stall = 1'b0;
    logic signed [DW-1:0] p_a, p_b;
    logic p_last;

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            q_a.push_back(bus.out_data_a);
            q_b.push_back(bus.out_data_b);
            q_last.push_back(bus.out_last);
        end
        if (o_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (bus.rd_en && bus.out_valid) n_rd_in_present++;
        if (prev_stall && (!bus.out_valid || bus.out_data_a !== p_a ||
                           bus.out_data_b !== p_b || bus.out_last !== p_last))
            n_hold_err++;
        prev_stall = bus.out_valid && !bus.out_ready;
        p_a = bus.out_data_a;
        p_b = bus.out_data_b;
        p_last = bus.out_last;
        if (o_argmax_idx != '0 || o_argmax_val != '0) n_amax_nz++;
    end

    int start_cyc = 0;
    logic rand_ready = 1'b0;

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 bus.out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic clear_mon();
        q_a.delete();
        q_b.delete();
        q_last.delete();
        n_done = 0;
        n_rd_in_present = 0;
        n_hold_err = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 i_start = 1'b1;
        @(posedge clk);
        #1 start_cyc = cyc;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (n_done == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n_done == 0) check_eq({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_pairs(input string tag, input int cnt, input int budget);
        int n = 0;
        while (q_a.size() < cnt && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (q_a.size() < cnt) check_eq({tag, "_timeout"}, q_a.size(), cnt);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_rd_en"}, bus.rd_en, 0);
        check_eq({tag, "_rd_addr"}, bus.rd_addr, 0);
        check_eq({tag, "_valid"}, bus.out_valid, 0);
        check_eq({tag, "_data_a"}, bus.out_data_a, 0);
        check_eq({tag, "_data_b"}, bus.out_data_b, 0);
        check_eq({tag, "_last"}, bus.out_last, 0);
        check_eq({tag, "_busy"}, o_busy, 0);
        check_eq({tag, "_done"}, o_done, 0);
        check_eq({tag, "_amax_idx"}, o_argmax_idx, 0);
        check_eq({tag, "_amax_val"}, o_argmax_val, 0);
    endtask

    // Compares the captured stream to the ramp RAM[i]=i
    task automatic verify_ramp(input string tag);
        check_eq({tag, "_pairs"}, q_a.size(), NP);
        check_eq({tag, "_dones"}, n_done, 1);
        for (int k = 0; k < NP && k < q_a.size(); k++) begin
            check_eq($sformatf("%s_a%0d", tag, k), q_a[k], 2 * k);
            check_eq($sformatf("%s_b%0d", tag, k), q_b[k], 2 * k + 1);
            check_eq($sformatf("%s_last%0d", tag, k), q_last[k], (k == NP - 1) ? 1 : 0);
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 128; i++) ram[i] = DW'(i);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        bus.rd_data = '0;
        load_ramp();
        repeat (3) @(posedge clk);
        #1 check_reset_state("reset");
        rst = 1'b0;

        // Ramp, ready tied high
        clear_mon();
        pulse_start();
        check_eq("ramp_busy", o_busy, 1);
        check_eq("ramp_rd_en", bus.rd_en, 1);
        check_eq("ramp_rd_addr0", bus.rd_addr, 0);
        wait_done("ramp", 400);
        verify_ramp("ramp");
        check_eq("ramp_done_latency", done_cyc - start_cyc, 240);
        check_eq("ramp_rd_in_present", n_rd_in_present, 0);
`ifdef FC_ARGMAX_EN
        check_eq("ramp_amax_idx", o_argmax_idx, 119);
        check_eq("ramp_amax_val", o_argmax_val, 119);
`endif
        @(posedge clk);
        #1 check_eq("ramp_idle_busy", o_busy, 0);

        // Random backpressure
        clear_mon();
        rand_ready = 1'b1;
        pulse_start();
        wait_done("bp", 3000);
        rand_ready = 1'b0;
        @(posedge clk);
        #2 bus.out_ready = 1'b1;
        verify_ramp("bp");
        check_eq("bp_hold_err", n_hold_err, 0);
        check_eq("bp_rd_in_present", n_rd_in_present, 0);

        // Reset during pair 30
        clear_mon();
        pulse_start();
        wait_pairs("rstmid", 30, 400);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 check_reset_state("rstmid");
        rst = 1'b0;
        clear_mon();
        pulse_start();
        wait_done("rstmid_re", 400);
        verify_ramp("rstmid_re");

        // Start pulsed again while busy during pair 10
        clear_mon();
        pulse_start();
        wait_pairs("busy_start", 10, 400);
        @(posedge clk);
        #1 i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        check_eq("busy_start_busy", o_busy, 1);
        wait_done("busy_start", 400);
        repeat (20) @(posedge clk);
        #1;
        verify_ramp("busy_start");
        check_eq("busy_start_idle", o_busy, 0);

`ifdef FC_ARGMAX_EN
        // Argmax: ties keep lower index, min value never wins
        for (int i = 0; i < 128; i++) ram[i] = -16'sd5;
        ram[37] = 16'sd700;
        ram[90] = 16'sd700;
        ram[3]  = -16'sd32768;
        clear_mon();
        pulse_start();
        wait_done("amax", 400);
        check_eq("amax_idx", o_argmax_idx, 37);
        check_eq("amax_val", o_argmax_val, 700);
        repeat (5) @(posedge clk);
        #1 check_eq("amax_hold_idx", o_argmax_idx, 37);

        for (int i = 0; i < 128; i++) ram[i] = -16'sd1;
        clear_mon();
        pulse_start();
        wait_done("amax_eq", 400);
        check_eq("amax_eq_idx", o_argmax_idx, 0);
        check_eq("amax_eq_val", o_argmax_val, -1);
`else
        check_eq("amax_tied_zero", n_amax_nz, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fc_result_drain.md
# fc_result_drain

Reads the 120-entry result buffer written by the fully connected layer once that layer reports completion, and streams the results out as lane pairs (entries 2k, 2k+1) over a valid/ready handshake. The stream matches the two-lane `in_1`/`in_2` input convention used by the next FC stage. The block sits between an FC layer's output RAM and the following layer or classifier. Optionally, it tracks the signed argmax over all drained entries.

## Interface
- `DATA_WIDTH`, 16, width of one signed result word
- `NUM_OUT`, 120, number of result entries to drain; must be even
- `ADDR_WIDTH`, 7, result RAM address width
- `clk`  in  1  clock
- `rst`  in  1  reset rst, synchronous, active-high; clock clk
- `start`  in  1  begin drain; sampled only in IDLE (connect to the FC layer's done level)
- `rd_en`  out  1  result RAM read enable
- `rd_addr`  out  ADDR_WIDTH  result RAM read address
- `rd_data`  in  DATA_WIDTH  signed RAM data, valid 1 cycle after `rd_addr`/`rd_en`
- `out_valid`  out  1  lane pair valid
- `out_ready`  in  1  downstream accepts pair
- `out_data_a`  out  DATA_WIDTH  entry 2k
- `out_data_b`  out  DATA_WIDTH  entry 2k+1
- `out_last`  out  1  current pair is the final pair (k = NUM_OUT/2-1)
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the final pair is accepted
- `argmax_idx`  out  ADDR_WIDTH  index of the largest entry
- `argmax_val`  out  DATA_WIDTH  value of the largest entry

## Operation
- FSM states: IDLE, RD0, RD1, CAP, PRESENT, DONE. Pair counter `k` runs from 0 to NUM_OUT/2-1.
- IDLE: if `start`=1, clear `k`, clear argmax, go to RD0. Otherwise stay in IDLE.
- RD0: `rd_en`=1, `rd_addr`=2k; go to RD1.
- RD1: `rd_en`=1, `rd_addr`=2k+1; capture `rd_data` into `out_data_a`; go to CAP.
- CAP: `rd_en`=0; capture `rd_data` into `out_data_b`; set `out_valid`; go to PRESENT.
- PRESENT: hold `out_valid`=1 until `out_valid && out_ready`.
  - On transfer with `k`=NUM_OUT/2-1: go to DONE.
  - On any other transfer: increment `k`, clear `out_valid`, go to RD0.
- DONE: `done`=1 for exactly this cycle; go to IDLE.
- Output stability: `out_data_a`, `out_data_b`, and `out_last` stay stable while `out_valid`=1 and `out_ready`=0.
- `out_last` = `out_valid` && (`k` == NUM_OUT/2-1).
- `start` asserted while `busy` is ignored. `start` held high continuously starts a new drain one cycle after DONE.
- Data is passed through unmodified: no saturation, no sign change.
- `rst` mid-drain aborts the drain. All state and outputs return to reset values on the next edge. No partial pair is emitted.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `out_valid`=0, `out_data_a`=0, `out_data_b`=0, `out_last`=0, `busy`=0, `done`=0, `argmax_idx`=0, `argmax_val`=0. State is IDLE.
- All outputs are registered.
- `start` sampled high at edge t gives RD0 and `rd_addr`=0 from t+1.
- Each pair costs 3 cycles from RD0 to `out_valid`. With `out_ready` tied high, throughput is one pair per 4 cycles. A full drain of 60 pairs is 240 cycles from `start` to the final transfer, with `done` in the next cycle.
- The RAM read latency is fixed at 1 cycle. No other latency is supported.

## Configuration
- `FC_ARGMAX_EN` defined:
  - On each capture (RD1 for lane a, CAP for lane b), compare the entry signed against `argmax_val`. Replace `argmax_val`/`argmax_idx` only if the entry is strictly greater.
  - Entry 0 always loads unconditionally.
  - Ties keep the lower index.
  - Outputs are final and stable from the DONE cycle until the next `start` or `rst`.
- `FC_ARGMAX_EN` undefined: `argmax_idx` and `argmax_val` are tied to 0 and no comparator logic is built. All other behaviour is identical.

## Test plan
- Ramp: RAM[i]=i, `out_ready`=1, `start` pulse.
  - 60 transfers with pairs (0,1), (2,3) … (118,119).
  - `out_last` high only on (118,119).
  - `done` high for 1 cycle, 240 cycles after `start`.
- Backpressure: `out_ready` toggles on a random pattern.
  - Data holds while stalled; no pair is lost or duplicated.
  - `rd_en` never asserts while in PRESENT.
- Reset mid-drain: assert `rst` during pair 30.
  - All outputs at reset values next cycle.
  - A new `start` restarts the drain at pair (0,1).
- Start while busy: pulse `start` again during pair 10.
  - Ignored; exactly 60 transfers and one `done`.
- Argmax (macro defined): all entries −5, except RAM[37]=700, RAM[90]=700, RAM[3]=−32768.
  - `argmax_idx`=37, `argmax_val`=700 at `done`.
  - All entries equal −1: `argmax_idx`=0, `argmax_val`=−1.
- Macro undefined: repeat the ramp test. Stream identical to the ramp test; `argmax_idx`=0 and `argmax_val`=0 throughout.
